fpadd_single: RTL and testbench

- IEEE-754 single-precision (binary32) floating-point adder.
- Adds two 32-bit operands and produces a 32-bit registered sum.
- Two-stage registered datapath:
  - input capture registers,
  - combinational align/add/normalize/round,
  - output register.
- Sits as a standalone arithmetic unit fed by a host or testbench that holds operands steady for two clock cycles.

---
 rtl/fpadd_pkg.sv | 27 ++
 rtl/fpadd_lzc.sv | 18 +
 rtl/fpadd_single.sv | 136 +++++++++++++
 tb/tb_fpadd_single.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// Shared binary32 format constants, the unpacked-field struct and small field predicates.
package fpadd_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned BIAS   = 127;
  // Working significand: hidden + fraction + guard/round/sticky.
  localparam int unsigned SIG_W  = FRAC_W + 4;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  function automatic logic is_nan(fp32_t x);
    return (x.exp == EXP_MAX) && (x.frac != '0);
  endfunction

  function automatic logic is_inf(fp32_t x);
    return (x.exp == EXP_MAX) && (x.frac == '0);
  endfunction

endpackage

// File: rtl/fpadd_lzc.sv
// Combinational leading-zero counter over the 27-bit working significand.
// An all-zero input reports SIG_W.
module fpadd_lzc
  import fpadd_pkg::*;
(
  input  logic [SIG_W-1:0] value,
  output logic [4:0]       count
);

  // Highest set bit wins because the scan runs upward and later hits overwrite.
  always_comb begin
    count = 5'(SIG_W);
    for (int i = 0; i < SIG_W; i++) begin
      if (value[i]) count = 5'(SIG_W - 1 - i);
    end
  end

endmodule

// File: rtl/fpadd_single.sv
// Binary32 adder: operand capture register, combinational align/add/normalize/round,
// registered result. Denormal inputs flush to zero; denormal results flush to signed zero.
module fpadd_single
  import fpadd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] reg_A,
  input  logic [31:0] reg_B,
  output logic [31:0] out
);

  fp32_t a_q, b_q;

  logic              a_zero, b_zero;
  logic [23:0]       a_sig, b_sig;
  logic [30:0]       a_mag, b_mag;
  logic              swap;
  logic              l_sign, s_sign;
  logic [EXP_W-1:0]  l_exp, s_exp, exp_diff;
  logic [23:0]       l_sig, s_sig;
  logic [49:0]       shift_ext;
  logic [SIG_W-1:0]  l_ext, s_ext;
  logic [SIG_W:0]    sum;
  logic [4:0]        lz;
  logic [SIG_W-1:0]  norm;
  logic signed [9:0] norm_exp, res_exp;
  logic              round_up;
  logic [24:0]       rounded;
  logic [FRAC_W-1:0] res_frac;
  logic [31:0]       result;

  // Operand capture stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= fp32_t'(reg_A);
      b_q <= fp32_t'(reg_B);
    end
  end

  // Unpack with flush-to-zero, then order operands by magnitude.
  always_comb begin
    a_zero = (a_q.exp == '0);
    b_zero = (b_q.exp == '0);
    a_sig  = a_zero ? 24'd0 : {1'b1, a_q.frac};
    b_sig  = b_zero ? 24'd0 : {1'b1, b_q.frac};
    a_mag  = a_zero ? 31'd0 : {a_q.exp, a_q.frac};
    b_mag  = b_zero ? 31'd0 : {b_q.exp, b_q.frac};
    swap   = (b_mag > a_mag);
    l_sign = swap ? b_q.sign : a_q.sign;
    s_sign = swap ? a_q.sign : b_q.sign;
    l_exp  = swap ? b_q.exp  : a_q.exp;
    s_exp  = swap ? a_q.exp  : b_q.exp;
    l_sig  = swap ? b_sig    : a_sig;
    s_sig  = swap ? a_sig    : b_sig;
  end

  // Align the smaller significand, keeping guard/round and folding the rest into sticky.
  always_comb begin
    exp_diff  = l_exp - s_exp;
    shift_ext = {s_sig, 26'd0} >> exp_diff;
    if (exp_diff >= 8'd26) begin
      s_ext = {26'd0, |s_sig};
    end else begin
      s_ext = {shift_ext[49:24], |shift_ext[23:0]};
    end
    l_ext = {l_sig, 3'b000};
    if (l_sign ^ s_sign) begin
      sum = {1'b0, l_ext} - {1'b0, s_ext};
    end else begin
      sum = {1'b0, l_ext} + {1'b0, s_ext};
    end
  end

  fpadd_lzc u_lzc (
    .value (sum[SIG_W-1:0]),
    .count (lz)
  );

  // Normalize: carry-out shifts right, otherwise shift out leading zeros.
  always_comb begin
    if (sum[SIG_W]) begin
      norm     = {sum[SIG_W:2], sum[1] | sum[0]};
      norm_exp = $signed({2'b00, l_exp}) + 10'sd1;
    end else begin
      norm     = sum[SIG_W-1:0] << lz;
      norm_exp = $signed({2'b00, l_exp}) - $signed({5'd0, lz});
    end
  end

  // Round to nearest even; a carry out of the significand bumps the exponent.
  always_comb begin
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[SIG_W-1:3]} + {24'd0, round_up};
    if (rounded[24]) begin
      res_frac = rounded[23:1];
      res_exp  = norm_exp + 10'sd1;
    end else begin
      res_frac = rounded[22:0];
      res_exp  = norm_exp;
    end
  end

  // Select special results ahead of the finite datapath.
  always_comb begin
    if (is_nan(a_q) || is_nan(b_q) || (is_inf(a_q) && is_inf(b_q) && (a_q.sign != b_q.sign))) begin
      result = QNAN;
    end else if (is_inf(a_q)) begin
      result = a_q;
    end else if (is_inf(b_q)) begin
      result = b_q;
    end else if (sum == '0) begin
      // Only two negative zeros keep a negative sign; cancellation gives +0.
      result = {l_sign & s_sign, 31'd0};
    end else if (res_exp >= 10'sd255) begin
      result = {l_sign, EXP_MAX, 23'd0};
    end else if (res_exp <= 10'sd0) begin
      result = {l_sign, 31'd0};
    end else begin
      result = {l_sign, res_exp[7:0], res_frac};
    end
  end

  // Result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
    end else begin
      out <= result;
    end
  end

endmodule

// File: tb/tb_fpadd_single.sv
// Self-checking bench for fpadd_single: directed cases, reset behaviour and a
// randomized pipelined stream checked against an exact-integer reference model.
module tb_fpadd_single;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] reg_A = '0;
  logic [31:0] reg_B = '0;
  logic [31:0] out;

  int checks = 0;
  int failures = 0;

  fpadd_single dut (
    .clk   (clk),
    .reset (reset),
    .reg_A (reg_A),
    .reg_B (reg_B),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: exact sum as a wide integer, then round-to-nearest-even by remainder.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic         sa, sb, s;
    int           ea, eb, emin, p, e, shift;
    logic [127:0] ma, mb, m, q, rem, half;
    sa = a[31];
    sb = b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255) return (sa == sb) ? a : 32'h7FC00000;
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 && eb == 0) return (sa && sb) ? 32'h80000000 : 32'h00000000;
    if (ea == 0) return b;
    if (eb == 0) return a;
    emin = (ea < eb) ? ea : eb;
    ma = {104'd0, 1'b1, a[22:0]} << (ea - emin);
    mb = {104'd0, 1'b1, b[22:0]} << (eb - emin);
    if (sa == sb) begin
      m = ma + mb;
      s = sa;
    end else if (ma > mb) begin
      m = ma - mb;
      s = sa;
    end else if (mb > ma) begin
      m = mb - ma;
      s = sb;
    end else begin
      return 32'h00000000;
    end
    p = 0;
    for (int i = 0; i < 128; i++) if (m[i]) p = i;
    if (p > 23) begin
      shift = p - 23;
      q     = m >> shift;
      rem   = m - (q << shift);
      half  = 128'd1 << (shift - 1);
      if (rem > half || (rem == half && q[0])) q = q + 128'd1;
    end else begin
      q = m << (23 - p);
    end
    e = emin + p - 23;
    if (q[24]) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), q[22:0]};
  endfunction

  // Apply a pair, check after two edges, then the swapped pair.
  task automatic apply_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
    reg_A = a;
    reg_B = b;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq(tag, out, exp);
    reg_A = b;
    reg_B = a;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq({tag, "_swap"}, out, exp);
  endtask

  function automatic logic [31:0] rand_normal(input int centre);
    int e;
    e = centre + int'($urandom_range(0, 60)) - 30;
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] ra, rb;
    int          centre;

    #1;
    check_eq("reset_init", out, 32'h00000000);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset mid-stream.
    apply_check("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000);
    reg_A = 32'h3F800000;
    reg_B = 32'h3F800000;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("reset_async", out, 32'h00000000);
    @(posedge clk);
    #1;
    check_eq("reset_held", out, 32'h00000000);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("reset_drain", out, 32'h00000000);
    @(posedge clk);
    #1;
    check_eq("reset_resume", out, 32'h40000000);

    // Basic arithmetic, rounding, cancellation and specials.
    apply_check("three_minus_one", 32'h40400000, 32'hBF800000, 32'h40000000);
    apply_check("cancel", 32'h3FC00000, 32'hBFC00000, 32'h00000000);
    apply_check("tie_even_down", 32'h3F800000, 32'h33800000, 32'h3F800000);
    apply_check("round_up", 32'h3F800000, 32'h34400000, 32'h3F800002);
    apply_check("tie_even_up", 32'h3F800001, 32'h33800000, 32'h3F800002);
    apply_check("big_lshift", 32'h3F800001, 32'hBF800000, 32'h34000000);
    apply_check("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    apply_check("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000);
    apply_check("inf_plus_one", 32'h7F800000, 32'h3F800000, 32'h7F800000);
    apply_check("neg_zeros", 32'h80000000, 32'h80000000, 32'h80000000);
    apply_check("denorm_flush", 32'h00000001, 32'h3F800000, 32'h3F800000);
    apply_check("nan_in", 32'h7F800001, 32'h3F800000, 32'h7FC00000);
    apply_check("sticky_sub", 32'h3F800000, 32'hB0000001, 32'h3F800000);
    apply_check("underflow", 32'h00800001, 32'h80800000, 32'h00000000);

    // Pipelined stream: new operands every cycle, each pair followed by its swap.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        centre = (i < 20) ? int'($urandom_range(20, 230)) : int'($urandom_range(1, 254));
        ra = rand_normal(centre);
        rb = rand_normal(int'(ra[30:23]));
        reg_A = ra;
        reg_B = rb;
      end else begin
        reg_A = rb;
        reg_B = ra;
      end
      exp_q.push_back(ref_add(ra, rb));
      @(posedge clk);
      #1;
      if (i >= 1) check_eq($sformatf("pipe%0d", i - 1), out, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    check_eq("pipe39", out, exp_q.pop_front());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
